// File: rtl/spi_cfg_pkg.sv
// Shared widths, default timing and FSM state encoding for the SPI configuration master.
package spi_cfg_pkg;
  localparam int FRAME_W   = 64;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BIT_CNT_W = 6;
  localparam int TMR_W     = 16;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_CS_GAP   = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;
endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider: emits rise/fall strobes one clk ahead of the spi_sclk level change.
module spi_sclk_gen
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_reg;
  logic             sclk_reg;
  logic             wrap;

  assign wrap = en && (div_reg == DIV_W'(CLK_DIV - 1));

  // Disabled generator parks low so every frame starts with a full low phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg  <= '0;
      sclk_reg <= 1'b0;
    end else if (!en) begin
      div_reg  <= '0;
      sclk_reg <= 1'b0;
    end else if (wrap) begin
      div_reg  <= '0;
      sclk_reg <= ~sclk_reg;
    end else begin
      div_reg  <= div_reg + 1'b1;
    end
  end

  assign rise = wrap && !sclk_reg;
  assign fall = wrap && sclk_reg;
  assign sclk = sclk_reg;
endmodule

// File: rtl/spi_cfg_master.sv
// Write-only SPI mode-0 frame master (64-bit address+data frames).
// Define SPI_RDBACK_EN to add MISO capture with rd_valid/rd_data outputs.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int CS_GAP   = DEF_CS_GAP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_valid,
  input  logic [FRAME_W-1:0] tx_data,
  output logic               tx_ready,
  output logic               spi_cs_n,
  output logic               spi_sclk,
  output logic               spi_mosi,
  input  logic               spi_miso,
  output logic               busy,
  output logic               done
`ifdef SPI_RDBACK_EN
  ,
  output logic               rd_valid,
  output logic [FRAME_W-1:0] rd_data
`endif
);
  spi_state_e           state_reg, state_next;
  logic [TMR_W-1:0]     tmr_reg;
  logic [BIT_CNT_W-1:0] bit_reg;
  logic [FRAME_W-1:0]   shift_reg;
  logic                 tx_ready_reg, done_reg;
  logic                 accept, frame_end, frame_active;
  logic                 sclk_en, sclk_rise, sclk_fall;

  assign accept    = tx_valid && tx_ready_reg && (state_reg == IDLE);
  assign frame_end = (state_reg == HOLD) && (state_next == GAP);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (sclk_en),
    .sclk (spi_sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   if (tmr_reg == TMR_W'(CS_SETUP - 1)) state_next = SHIFT;
      SHIFT:   if (sclk_fall && (bit_reg == '1)) state_next = HOLD;
      HOLD:    if (tmr_reg == TMR_W'(CS_HOLD - 1)) state_next = GAP;
      GAP:     if (tmr_reg == TMR_W'(CS_GAP - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    frame_active = (state_reg == SETUP) || (state_reg == SHIFT) || (state_reg == HOLD);
    busy         = (state_reg != IDLE);
    spi_cs_n     = !frame_active;
    spi_mosi     = frame_active && shift_reg[FRAME_W-1];
    sclk_en      = (state_reg == SHIFT);
  end

  // tx_ready is registered so it first rises on the clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready_reg <= 1'b0;
      done_reg     <= 1'b0;
      tmr_reg      <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
    end else begin
      tx_ready_reg <= (state_next == IDLE);
      done_reg     <= frame_end;
      if ((state_next != state_reg) || (state_reg == IDLE)) tmr_reg <= '0;
      else                                                  tmr_reg <= tmr_reg + 1'b1;
      if (accept) begin
        shift_reg <= tx_data;
        bit_reg   <= '0;
      end else if (sclk_fall) begin
        shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
        bit_reg   <= bit_reg + 1'b1;
      end
    end
  end

  assign tx_ready = tx_ready_reg;
  assign done     = done_reg;

`ifdef SPI_RDBACK_EN
  logic [FRAME_W-1:0] cap_reg, rd_data_reg;
  logic               rd_valid_reg;

  // MISO is captured on the same clk edge that raises SCLK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_reg      <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      if (sclk_rise) cap_reg <= {cap_reg[FRAME_W-2:0], spi_miso};
      rd_valid_reg <= frame_end;
      if (frame_end) rd_data_reg <= cap_reg;
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
`endif
endmodule

// File: doc/spi_cfg_master.md
SPI_CFG_MASTER -- requirements
Module: spi_cfg_master

Interface
REQ-001 Param CLK_DIV, default 4: SCLK half-period in clk cycles; legal range is 1 or more.
REQ-002 Param CS_SETUP, default 2: clk cycles from CS_N fall to first SCLK rise-phase start; legal range is 1 or more.
REQ-003 Param CS_HOLD, default 2: clk cycles from last SCLK fall to CS_N rise; legal range is 1 or more.
REQ-004 Param CS_GAP, default 4: clk cycles CS_N stays high before the next frame may start; legal range is 1 or more.
REQ-005 clk  in  1  single block clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-007 tx_valid  in  1  frame request.
REQ-008 tx_data  in  64  frame: [63:32] register address (e.g. 32'h43C0_3100), [31:0] write data.
REQ-009 tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid and tx_ready are both high on a rising clk edge.
REQ-010 spi_cs_n  out  1  chip select, active-low.
REQ-011 spi_sclk  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-012 spi_mosi  out  1  serial data, MSB (bit 63) first.
REQ-013 spi_miso  in  1  serial readback data (used only with SPI_RDBACK_EN).
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 done  out  1  single-cycle pulse in the cycle CS_N returns high.

Function
REQ-016 FSM states and transitions: IDLE -> SETUP on accept; SETUP -> SHIFT after CS_SETUP cycles; SHIFT -> HOLD after 64 bits; HOLD -> GAP after CS_HOLD cycles; GAP -> IDLE after CS_GAP cycles.
REQ-017 On accept, the block latches tx_data into a 64-bit shift register; later changes to tx_data do not affect the frame in flight.
REQ-018 Cycle after accept: spi_cs_n=0, spi_mosi=bit 63, spi_sclk=0.
REQ-019 SHIFT bit timing: each bit is CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
REQ-020 MOSI updates only at the SCLK falling edge (start of the next bit's low phase) and is stable for the entire high phase.
REQ-021 A 6-bit bit counter counts 0..63; SHIFT ends after the high phase of bit 63 with SCLK driven low.
REQ-022 CS_N low duration = CS_SETUP + 128*CLK_DIV + CS_HOLD cycles; with defaults this is 516 cycles.
REQ-023 done is high for exactly one cycle, on the HOLD->GAP transition; spi_mosi is driven 0 outside SETUP/SHIFT/HOLD.
REQ-024 tx_valid asserted while busy is ignored, with no queuing; back-to-back frames are separated by at least CS_GAP+1 cycles of CS_N high.
REQ-025 tx_valid held continuously high: the next frame is accepted in the first IDLE cycle.

Reset
REQ-026 Asynchronous rst_n=0 forces immediately: state IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, tx_ready=0, counters=0, shift register=0, rd_valid=0, rd_data=0.
REQ-027 tx_ready rises on the first clk edge after rst_n deasserts.
REQ-028 Reset mid-frame aborts the frame with no done pulse; the frame is not resumed after reset.

Configuration
REQ-029 Macro SPI_RDBACK_EN defined: the block adds output ports rd_valid (out, 1) and rd_data (out, 64).
REQ-030 With SPI_RDBACK_EN, spi_miso is sampled at each SCLK rising edge, MSB first, into a capture register.
REQ-031 With SPI_RDBACK_EN, rd_data updates and rd_valid pulses for one cycle coincident with done.
REQ-032 Macro SPI_RDBACK_EN undefined: rd_valid and rd_data are absent, spi_miso is unconnected internally, and no capture register is built.

Structure
REQ-033 Shared package spi_cfg_pkg holds: FRAME_W=64, ADDR_W=32, DATA_W=32, FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP), and default timing constants.
REQ-034 One sub-module, spi_sclk_gen, holds the half-period divider and produces rise/fall strobes plus the spi_sclk level.
REQ-035 The FSM, shift register and capture register live in the top module.

Verification
REQ-036 Reset, then tx_data=64'h43C0_3100_0000_1234 -> the slave model decodes address 43C0_3100, data 0000_1234; CS_N low for 516 cycles; one done pulse.
REQ-037 tx_valid held high with two frames queued by the bench -> the second CS_N fall occurs at least 5 cycles after the first CS_N rise; tx_ready is low throughout both frames.
REQ-038 tx_data changed and tx_valid pulsed mid-frame -> the transmitted frame is unchanged and the extra request is dropped.
REQ-039 rst_n pulsed low at bit 20 -> CS_N goes high, SCLK and MOSI go 0 asynchronously, no done pulse; a new frame after reset transmits correctly.
REQ-040 CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, CS_GAP=1 -> CS_N low for 130 cycles; MOSI is stable across every SCLK high phase.
REQ-041 SPI_RDBACK_EN build, slave returns 64'hDEAD_BEEF_0123_4567 -> rd_data equals that value and rd_valid coincides with done.
